// File: rtl/uart_rx_param.sv
// Parametrised 16x-oversampled UART receiver with parity/stop checking, error flags and valid/ready output.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote on every decision sample.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_i,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS + 1);

  localparam logic [DW-1:0] DIV_LAST     = DW'(DIV - 1);
  localparam logic [SW-1:0] SC_HALF      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_FULL      = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BC_STOP_LAST = BW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 sync1_q, rxs_q;
  logic [DW-1:0]        div_q;
  logic                 tick;
  logic                 armed_q;
  logic                 samp;
  logic                 par_exp;
  logic [2:0]           state_q, state_d;
  logic [SW-1:0]        sc_q, sc_d;
  logic [BW-1:0]        bc_q, bc_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done_q, done_d;
  logic                 valid_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 perr_out_q, ferr_out_q, ovr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rxs_q   <= sync1_q;
    end
  end

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + DW'(1);
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     hist_q <= 2'b11;
    else if (tick) hist_q <= {hist_q[0], rxs_q};
  end

  assign samp = (rxs_q & hist_q[0]) | (rxs_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign samp = rxs_q;
`endif

  assign par_exp = (PARITY == 1) ? ~(^shift_q) : (^shift_q);

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bc_d    = bc_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (armed_q && !rxs_q) begin
            state_d = S_START;
            sc_d    = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        S_START: begin
          if (sc_q == SC_HALF) begin
            sc_d    = '0;
            bc_d    = '0;
            state_d = samp ? S_IDLE : S_DATA;
          end else begin
            sc_d = sc_q + SW'(1);
          end
        end
        S_DATA: begin
          if (sc_q == SC_FULL) begin
            sc_d    = '0;
            shift_d = {samp, shift_q[DATA_BITS-1:1]};
            if (bc_q == BC_DATA_LAST) begin
              bc_d    = '0;
              state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bc_d = bc_q + BW'(1);
            end
          end else begin
            sc_d = sc_q + SW'(1);
          end
        end
        S_PARITY: begin
          if (sc_q == SC_FULL) begin
            sc_d    = '0;
            state_d = S_STOP;
            if (samp != par_exp) perr_d = 1'b1;
          end else begin
            sc_d = sc_q + SW'(1);
          end
        end
        S_STOP: begin
          if (sc_q == SC_FULL) begin
            sc_d = '0;
            if (!samp) ferr_d = 1'b1;
            // Return to IDLE at the stop-bit centre so a following start edge is not missed.
            if (bc_q == BC_STOP_LAST) begin
              bc_d    = '0;
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              bc_d = bc_q + BW'(1);
            end
          end else begin
            sc_d = sc_q + SW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sc_q    <= '0;
      bc_q    <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bc_q    <= bc_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
    end
  end

  // Disarm on a framing error so a held-low (break) line yields a single frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  armed_q <= 1'b0;
    else if (done_d && ferr_d)  armed_q <= 1'b0;
    else if (tick && rxs_q)     armed_q <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else if (done_q) begin
      if (!valid_q || rx_ready) begin
        valid_q    <= 1'b1;
        data_q     <= shift_q;
        perr_out_q <= perr_q;
        ferr_out_q <= ferr_q;
        ovr_q      <= 1'b0;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign rx_valid    = valid_q;
  assign rx_data     = data_q;
  assign parity_err  = perr_out_q;
  assign frame_err   = ferr_out_q;
  assign overrun_err = ovr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and an 8E1 instance, 16 clk per bit.
module tb_uart_rx_param;

  logic       clk;
  logic       reset;
  logic       rx_a, ready_a, valid_a, pe_a, fe_a, ov_a, busy_a;
  logic [7:0] data_a;
  logic       rx_b, ready_b, valid_b, pe_b, fe_b, ov_b, busy_b;
  logic [7:0] data_b;

  int checks = 0;
  int errors = 0;
  int hs_a = 0, vcyc_a = 0, hs_b = 0;
  logic [7:0] cap_data_a, cap_data_b;
  logic       cap_pe_a, cap_fe_a, cap_pe_b, cap_fe_b;
  int h0, v0;
  logic [7:0] glitch_exp;

  uart_rx_param #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_dut (
    .clk(clk), .reset(reset), .rx_i(rx_a), .rx_valid(valid_a), .rx_ready(ready_a),
    .rx_data(data_a), .parity_err(pe_a), .frame_err(fe_a), .overrun_err(ov_a), .busy(busy_a)
  );

  uart_rx_param #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) u_par (
    .clk(clk), .reset(reset), .rx_i(rx_b), .rx_valid(valid_b), .rx_ready(ready_b),
    .rx_data(data_b), .parity_err(pe_b), .frame_err(fe_b), .overrun_err(ov_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted word; inputs change 1 time unit after posedge, so negedge is race-free.
  always @(negedge clk) begin
    if (valid_a) vcyc_a++;
    if (valid_a && ready_a) begin
      hs_a++;
      cap_data_a = data_a;
      cap_pe_a   = pe_a;
      cap_fe_a   = fe_a;
    end
    if (valid_b && ready_b) begin
      hs_b++;
      cap_data_b = data_b;
      cap_pe_b   = pe_b;
      cap_fe_b   = fe_b;
    end
  end

  task automatic wclk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int which, input logic b, input int n);
    if (which == 0) rx_a = b;
    else            rx_b = b;
    wclk(n);
  endtask

  task automatic send(input int which, input logic [7:0] d, input bit with_par,
                      input logic par, input logic stop);
    drive(which, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(which, d[i], 16);
    if (with_par) drive(which, par, 16);
    drive(which, stop, 16);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    rx_a    = 1'b1;
    rx_b    = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    wclk(3);
    chk("reset_valid", valid_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_data", data_a, 0);
    chk("reset_flags", {pe_a, fe_a, ov_a}, 0);
    chk("reset_valid_par", valid_b, 0);
    reset = 1'b0;
    wclk(4);

    // 8N1 word with consumer ready: one-cycle valid pulse
    h0 = hs_a; v0 = vcyc_a;
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wclk(16);
    chk("t1_handshakes", hs_a - h0, 1);
    chk("t1_valid_cycles", vcyc_a - v0, 1);
    chk("t1_data", cap_data_a, 8'hA5);
    chk("t1_pe_fe", {cap_pe_a, cap_fe_a}, 0);
    chk("t1_overrun", ov_a, 0);
    chk("t1_busy_idle", busy_a, 0);

    // Even parity: 0x37 has five ones, so the correct parity bit is 1
    h0 = hs_b;
    send(1, 8'h37, 1'b1, 1'b0, 1'b1);
    wclk(16);
    chk("t2_bad_data", cap_data_b, 8'h37);
    chk("t2_bad_pe", cap_pe_b, 1);
    chk("t2_bad_fe", cap_fe_b, 0);
    send(1, 8'h37, 1'b1, 1'b1, 1'b1);
    wclk(16);
    chk("t2_good_data", cap_data_b, 8'h37);
    chk("t2_good_pe", cap_pe_b, 0);
    chk("t2_handshakes", hs_b - h0, 2);

    // Low stop bit, line kept low for 20 more bits: one frame, then nothing
    h0 = hs_a;
    send(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b0, 320);
    chk("t3_busy_in_break", busy_a, 0);
    chk("t3_handshakes", hs_a - h0, 1);
    chk("t3_data", cap_data_a, 8'h3C);
    chk("t3_fe", cap_fe_a, 1);
    chk("t3_pe", cap_pe_a, 0);
    drive(0, 1'b1, 32);
    send(0, 8'h81, 1'b0, 1'b0, 1'b1);
    wclk(16);
    chk("t3_after_handshakes", hs_a - h0, 2);
    chk("t3_after_data", cap_data_a, 8'h81);
    chk("t3_after_fe", cap_fe_a, 0);

    // 4-clk low glitch in IDLE: false start
    h0 = hs_a;
    drive(0, 1'b0, 4);
    rx_a = 1'b1;
    wclk(2);
    chk("t4_busy_start", busy_a, 1);
    wclk(20);
    chk("t4_busy_end", busy_a, 0);
    chk("t4_handshakes", hs_a - h0, 0);
    chk("t4_valid", valid_a, 0);

    // Overrun while consumer stalls
    ready_a = 1'b0;
    send(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send(0, 8'h22, 1'b0, 1'b0, 1'b1);
    send(0, 8'h33, 1'b0, 1'b0, 1'b1);
    wclk(16);
    chk("t5_valid", valid_a, 1);
    chk("t5_data", data_a, 8'h11);
    chk("t5_overrun", ov_a, 1);
    ready_a = 1'b1;
    wclk(1);
    ready_a = 1'b0;
    chk("t5_valid_after_hs", valid_a, 0);
    chk("t5_overrun_after_hs", ov_a, 0);
    chk("t5_data_held", data_a, 8'h11);
    send(0, 8'h44, 1'b0, 1'b0, 1'b1);
    wclk(16);
    chk("t5_next_valid", valid_a, 1);
    chk("t5_next_data", data_a, 8'h44);
    chk("t5_next_overrun", ov_a, 0);
    ready_a = 1'b1;
    wclk(1);
    chk("t5_next_cleared", valid_a, 0);

    // Reset in the middle of data bit 4 of 0x5A
    h0 = hs_a;
    drive(0, 1'b0, 16);
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 16);
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 16);
    drive(0, 1'b1, 8);
    reset = 1'b1;
    rx_a  = 1'b1;
    wclk(2);
    chk("t6_reset_data", data_a, 0);
    chk("t6_reset_busy", busy_a, 0);
    reset = 1'b0;
    wclk(20);
    chk("t6_no_word", hs_a - h0, 0);
    chk("t6_valid", valid_a, 0);
    send(0, 8'hC3, 1'b0, 1'b0, 1'b1);
    wclk(16);
    chk("t6_handshakes", hs_a - h0, 1);
    chk("t6_data", cap_data_a, 8'hC3);

    // 0xF0 with a 1-clk high glitch landing on the bit-3 decision sample
    h0 = hs_a;
    drive(0, 1'b0, 16);
    for (int i = 0; i < 3; i++) drive(0, 1'b0, 16);
    drive(0, 1'b0, 8);
    drive(0, 1'b1, 1);
    drive(0, 1'b0, 7);
    for (int i = 0; i < 4; i++) drive(0, 1'b1, 16);
    drive(0, 1'b1, 16);
    wclk(16);
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'hF0;
`else
    glitch_exp = 8'hF8;
`endif
    chk("t7_handshakes", hs_a - h0, 1);
    chk("t7_data", cap_data_a, glitch_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
